mux_n_1_seq: RTL and testbench
==============================

Name: mux_n_1_seq

Overview:
- Parametrised N-channel, W-bit registered selector with a valid/ready output handshake.
- Generalises the fixed 12-input combinational mux used in the decrypt datapath to any channel count.
- Adds an auto-scan mode that streams every channel in order, so the key/pixel operand banks can be serialised into the modular-arithmetic units without an external counter.

Parameters:
- N, 12, number of input channels (N >= 2).
- W, 5, data width per channel in bits.
- DEF_CH, 9, channel returned for an out-of-range select (0 <= DEF_CH < N).
- SELW, $clog2(N), select/index width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  N*W  flattened channels; channel k occupies bits [k*W +: W].
- mode  in  1  0 = direct select, 1 = auto-scan; sampled only on acceptance.
- sel  in  SELW  channel index for direct mode.
- sel_valid  in  1  direct-mode request.
- sel_ready  out  1  direct request can be accepted this cycle.
- start  in  1  single-cycle scan trigger.
- out_data  out  W  registered selected data.
- out_chan  out  SELW  index of the channel held in out_data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse after the last scan beat is accepted.
- sel_err  out  1  sticky out-of-range flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, any time, including mid-scan) forces state IDLE, index 0, and all outputs 0 (out_data, out_chan, out_valid, busy, done, sel_err). sel_ready is combinational and reads 1 after reset.
- Definitions:
  - slot_free = !out_valid || out_ready.
  - Accepted beat = out_valid && out_ready.
- States: IDLE, SCAN.
- IDLE:
  - sel_ready = slot_free.
  - If start && mode=1: go to SCAN with idx=0. start takes priority over a simultaneous sel_valid, which is not accepted.
  - Else if sel_valid && sel_ready: next edge loads out_data = in_data[ch], out_chan = ch, out_valid = 1.
    - ch = sel if sel < N, else DEF_CH.
    - Latency is 1 cycle from acceptance.
  - start with mode=0 is ignored.
- SCAN:
  - busy = 1 and sel_ready = 0; sel_valid is ignored.
  - Each cycle with slot_free and idx < N: load channel idx, set out_valid, increment idx.
  - With out_ready held high, throughput is one channel per cycle.
  - When the beat carrying channel N-1 is accepted: done = 1 for that following cycle, busy clears, and the state returns to IDLE.
  - start during SCAN is ignored; no restart.
- If no new load occurs on an accepted beat, out_valid clears on the next edge.
- While out_valid && !out_ready, out_data and out_chan must be held stable (backpressure). in_data changes during a stall are not reflected.
- in_data is sampled only on the load edge.
- The index register never exceeds N, and there is no wrap-around within one scan.

Optional Feature:
- Macro: MUX_SEL_ERR_EN.
- Defined: a direct request with sel >= N is still accepted, but loads out_data = 0 and out_chan = DEF_CH, and sets sel_err. sel_err stays set until rst.
- Not defined: out-of-range selects fall back silently to channel DEF_CH, and sel_err is tied to 0.

Test Plan:
- Direct select: N=12, W=5, channel k = k+3, sel=4, sel_valid pulse, out_ready=1 -> next cycle out_data=7, out_chan=4, out_valid=1; out_valid=0 one cycle later.
- Out-of-range select: sel=14 with macro undefined -> out_data=12 (channel 9), sel_err=0. With MUX_SEL_ERR_EN defined -> out_data=0, out_chan=9, sel_err=1, held until rst.
- Full scan: mode=1, start pulse, out_ready=1 -> out_chan 0..11 on 12 consecutive cycles, data 3..14; done high exactly one cycle after the beat for channel 11; busy low afterwards.
- Backpressure: during a scan, drop out_ready for 3 cycles at channel 5 while changing in_data -> out_data/out_chan frozen at the channel-5 values; channel 6 follows one cycle after out_ready returns.
- Simultaneous start and sel_valid in IDLE with mode=1 -> scan begins; the direct request is not accepted (sel_ready=0 from the next cycle until done).
- Reset mid-scan at channel 7 -> all outputs 0 immediately (asynchronous); a subsequent start scans again from channel 0.

Source files
------------

// File: rtl/mux_n_1_seq.sv
// mux_n_1_seq -- N-channel, W-bit registered selector with a valid/ready
// output handshake and an auto-scan mode that streams channels 0..N-1.
//
// Optional feature macro: MUX_SEL_ERR_EN
//   defined   : an out-of-range direct select loads zero data on channel
//               DEF_CH and sets the sticky sel_err flag.
//   undefined : an out-of-range direct select falls back to channel DEF_CH;
//               sel_err is tied to 0.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_data   [N*W]     flattened channels, channel k at [k*W +: W]
//   mode                0 = direct select, 1 = auto-scan (used with start)
//   sel, sel_valid      direct-mode request
//   sel_ready           direct request can be accepted this cycle
//   start               single-cycle scan trigger
//   out_data, out_chan  registered data and its channel index
//   out_valid/out_ready output handshake
//   busy                scan in progress
//   done                one-cycle pulse after the last scan beat is accepted
//   sel_err             sticky out-of-range flag
module mux_n_1_seq #(
  parameter int N      = 12,
  parameter int W      = 5,
  parameter int DEF_CH = 9,
  parameter int SELW   = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*W-1:0]    in_data,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic              sel_valid,
  output logic              sel_ready,
  input  logic              start,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              sel_err
);

  localparam int              IW      = SELW + 1;
  // Index is one bit wider than a channel number so it can reach N.
  localparam logic [IW-1:0]   N_IDX   = IW'(N);
  localparam logic [SELW-1:0] DEF_SEL = SELW'(DEF_CH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [W-1:0]    chans [N];

  logic            slot_free;
  logic            scan_go;
  logic            dir_load;
  logic            scan_load;
  logic            scan_end;
  logic            in_range;
  logic [SELW-1:0] load_ch;
  logic [W-1:0]    load_data;

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign chans[k] = in_data[k*W +: W];
  end

  // Stage p0: request decode and channel selection
  always_comb begin
    slot_free = !out_valid || out_ready;
    busy      = (state == SCAN);
    sel_ready = (state == IDLE) && slot_free;
    // A scan trigger wins over a simultaneous direct request.
    scan_go   = (state == IDLE) && start && mode;
    dir_load  = (state == IDLE) && !scan_go && sel_valid && slot_free;
    scan_load = (state == SCAN) && slot_free && (idx < N_IDX);
    // idx == N means channel N-1 is the beat currently held.
    scan_end  = (state == SCAN) && (idx == N_IDX) && out_valid && out_ready;
    in_range  = ({1'b0, sel} < N_IDX);
    load_ch   = DEF_SEL;
    load_data = '0;
    if (dir_load) begin
      load_ch   = in_range ? sel : DEF_SEL;
      load_data = chans[load_ch];
`ifdef MUX_SEL_ERR_EN
      if (!in_range) load_data = '0;
`endif
    end else if (scan_load) begin
      load_ch   = idx[SELW-1:0];
      load_data = chans[load_ch];
    end
  end

  // Stage p1: output register, scan index and state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= scan_end;
      if (scan_go) begin
        state <= SCAN;
        idx   <= '0;
      end else if (scan_end) begin
        state <= IDLE;
        idx   <= '0;
      end else if (scan_load) begin
        idx <= idx + 1'b1;
      end
      if (dir_load || scan_load) begin
        out_data  <= load_data;
        out_chan  <= load_ch;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_SEL_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (dir_load && !in_range) begin
      sel_err <= 1'b1;
    end
  end
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_1_seq.sv
// Scoreboard bench for mux_n_1_seq: stimulus pushes expected beats into a
// queue, a negedge monitor pops and compares every accepted output beat.
module tb_mux_n_1_seq;
  localparam int N      = 12;
  localparam int W      = 5;
  localparam int DEF_CH = 9;
  localparam int SELW   = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic [N*W-1:0]  in_data;
  logic            mode;
  logic [SELW-1:0] sel;
  logic            sel_valid;
  logic            sel_ready;
  logic            start;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_chan;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            done;
  logic            sel_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [SELW-1:0] chan;
    logic [W-1:0]    data;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;

  mux_n_1_seq #(.N(N), .W(W), .DEF_CH(DEF_CH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .mode(mode), .sel(sel),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .start(start),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pattern(input int base);
    for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(k + base);
  endtask

  task automatic push_scan(input int last);
    for (int k = 0; k <= last; k++) exp_q.push_back({SELW'(k), W'(k + 3)});
  endtask

  // Tick until done, checking that direct requests are blocked while busy.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 60) begin
      chk("busy_blocks_sel", {30'd0, busy, sel_ready}, 2);
      tick();
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  // Monitor: every accepted beat must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat chan %0d data %0d expected no beat", out_chan, out_data);
      end else begin
        mon_b = exp_q.pop_front();
        chk("beat_chan", out_chan, mon_b.chan);
        chk("beat_data", out_data, mon_b.data);
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; mode = 1'b0; sel = '0; sel_valid = 1'b0; start = 1'b0;
    out_ready = 1'b0;
    set_pattern(3);
    repeat (2) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_chan", out_chan, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sel_err", sel_err, 0);
    rst = 1'b0;
    #1;
    chk("sel_ready_after_rst", sel_ready, 1);

    // Direct select of channel 4
    out_ready = 1'b1; sel = SELW'(4); sel_valid = 1'b1;
    exp_q.push_back({SELW'(4), W'(7)});
    tick();
    sel_valid = 1'b0;
    chk("direct_valid", out_valid, 1);
    chk("direct_data", out_data, 7);
    chk("direct_chan", out_chan, 4);
    tick();
    chk("direct_valid_clear", out_valid, 0);

    // Out-of-range select
    sel = SELW'(14); sel_valid = 1'b1;
`ifdef MUX_SEL_ERR_EN
    exp_q.push_back({SELW'(DEF_CH), W'(0)});
`else
    exp_q.push_back({SELW'(DEF_CH), W'(12)});
`endif
    tick();
    sel_valid = 1'b0;
    tick();
    tick();
`ifdef MUX_SEL_ERR_EN
    chk("sel_err_set", sel_err, 1);
`else
    chk("sel_err_tied", sel_err, 0);
`endif

    // Direct request under backpressure, in_data changes during the stall
    out_ready = 1'b0; sel = SELW'(2); sel_valid = 1'b1;
    exp_q.push_back({SELW'(2), W'(5)});
    tick();
    sel_valid = 1'b0;
    chk("stall_valid", out_valid, 1);
    chk("stall_sel_ready", sel_ready, 0);
    set_pattern(20);
    tick();
    chk("stall_hold_data", out_data, 5);
    set_pattern(3);
    out_ready = 1'b1;
    tick();
    chk("stall_release", out_valid, 0);

    // Full scan with a start pulse in the middle that must be ignored
    mode = 1'b1; start = 1'b1;
    push_scan(11);
    tick();
    start = 1'b0;
    chk("scan_busy", busy, 1);
    chk("scan_sel_ready", sel_ready, 0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(3, n);
    chk("scan_len", n, 14);
    chk("busy_at_done", busy, 0);
    tick();
    chk("done_one_cycle", done, 0);
    chk("scan_end_valid", out_valid, 0);

    // Scan with a 3-cycle stall at channel 5
    start = 1'b1;
    push_scan(11);
    tick();
    start = 1'b0;
    n = 1;
    while (!(out_valid && out_chan == SELW'(5)) && n < 30) begin
      tick();
      n++;
    end
    chk("reach_ch5", out_chan, 5);
    out_ready = 1'b0;
    set_pattern(20);
    for (int i = 0; i < 3; i++) begin
      tick();
      n++;
      chk("bp_chan_hold", out_chan, 5);
      chk("bp_data_hold", out_data, 8);
    end
    set_pattern(3);
    out_ready = 1'b1;
    tick();
    n++;
    chk("bp_next_chan", out_chan, 6);
    chk("bp_next_data", out_data, 9);
    wait_done(n, n);
    chk("bp_scan_len", n, 17);

    // Simultaneous start and sel_valid: scan wins, request held off
    sel = SELW'(3); sel_valid = 1'b1; start = 1'b1;
    #1;
    chk("sel_ready_idle", sel_ready, 1);
    push_scan(11);
    tick();
    start = 1'b0;
    wait_done(1, n);
    sel_valid = 1'b0;
    chk("simul_scan_len", n, 14);

`ifdef MUX_SEL_ERR_EN
    chk("sel_err_sticky", sel_err, 1);
`else
    chk("sel_err_still_0", sel_err, 0);
`endif

    // Asynchronous reset while channel 7 is presented
    start = 1'b1;
    push_scan(6);
    tick();
    start = 1'b0;
    n = 1;
    while (!(out_valid && out_chan == SELW'(7)) && n < 30) begin
      tick();
      n++;
    end
    chk("reach_ch7", out_chan, 7);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_chan", out_chan, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sel_err", sel_err, 0);
    chk("arst_queue", exp_q.size(), 0);
    tick();
    rst = 1'b0;
    start = 1'b1;
    push_scan(11);
    tick();
    start = 1'b0;
    wait_done(1, n);
    chk("rescan_len", n, 14);
    tick();
    chk("queue_empty_end", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
